// File: rtl/fast_circle_compare.sv
// -----------------------------------------------------------------------------
// fast_circle_compare
//
// Front end of the FAST keypoint path. Each sample carries a centre pixel, its
// 16 Bresenham-circle neighbours and a threshold. Every neighbour is classified
// as bright (> c+t), dark (< c-t) or similar, producing the bright/dark masks
// used by the contiguous-arc detector, a high-speed-test candidate flag and a
// corner score. Fully pipelined: one sample per clock, latency 3, no stalls.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      sample strobe
//   i_center     centre pixel intensity               [PIX_W]
//   i_circle     pixel k at [k*PIX_W +: PIX_W]        [16*PIX_W]
//   i_threshold  FAST threshold, per sample           [PIX_W]
//   o_valid      result strobe (i_valid delayed by 3)
//   o_bright     bit k set when pixel k > hi          [16]
//   o_dark       bit k set when pixel k < lo          [16]
//   o_candidate  high-speed test pass (pixels 0,4,8,12)
//   o_score      max(sum of bright excess, sum of dark excess) [PIX_W+4]
// -----------------------------------------------------------------------------
module fast_circle_compare #(
   parameter int PIX_W  = 8,
   parameter int HS_MIN = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [PIX_W-1:0]     i_center,
   input  logic [16*PIX_W-1:0]  i_circle,
   input  logic [PIX_W-1:0]     i_threshold,
   output logic                 o_valid,
   output logic [15:0]          o_bright,
   output logic [15:0]          o_dark,
   output logic                 o_candidate,
   output logic [PIX_W+3:0]     o_score
);

   localparam int SCORE_W = PIX_W + 4;
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   // ---------------------------------------------------------------- stage 1
   logic [PIX_W:0]   hi_sum;
   logic [PIX_W:0]   lo_diff;
   logic [PIX_W-1:0] hi_sat;
   logic [PIX_W-1:0] lo_sat;

   // One extra bit catches carry (hi overflow) and borrow (lo underflow).
   always_comb begin
      hi_sum  = {1'b0, i_center} + {1'b0, i_threshold};
      lo_diff = {1'b0, i_center} - {1'b0, i_threshold};
      hi_sat  = hi_sum[PIX_W]  ? PIX_MAX : hi_sum[PIX_W-1:0];
      lo_sat  = lo_diff[PIX_W] ? '0      : lo_diff[PIX_W-1:0];
   end

   logic                s1_valid;
   logic [PIX_W-1:0]    s1_hi;
   logic [PIX_W-1:0]    s1_lo;
   logic [16*PIX_W-1:0] s1_circle;

   // NOTE: every sequential assignment is non-blocking so all stages sample
   // the previous cycle's values at the same edge regardless of block order.
   // NOTE: data registers are reset along with the valids so outputs are a
   // known 0 after reset; they are plain flops, not a memory array.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid  <= 1'b0;
         s1_hi     <= '0;
         s1_lo     <= '0;
         s1_circle <= '0;
      end else begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_hi     <= hi_sat;
            s1_lo     <= lo_sat;
            s1_circle <= i_circle;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [15:0]      bright_c;
   logic [15:0]      dark_c;
   logic [PIX_W-1:0] db_c [16];
   logic [PIX_W-1:0] dd_c [16];

   // NOTE: every output gets a default before the loop; without it the
   // conditional assignments would infer latches.
   always_comb begin
      logic [PIX_W-1:0] pix;
      bright_c = '0;
      dark_c   = '0;
      pix      = '0;
      for (int k = 0; k < 16; k++) begin
         db_c[k] = '0;
         dd_c[k] = '0;
         pix     = s1_circle[k*PIX_W +: PIX_W];
         // hi >= lo always, so the two classes can never both be true.
         if (pix > s1_hi) begin
            bright_c[k] = 1'b1;
            db_c[k]     = pix - s1_hi;
         end else if (pix < s1_lo) begin
            dark_c[k] = 1'b1;
            dd_c[k]   = s1_lo - pix;
         end
      end
   end

   logic             s2_valid;
   logic [15:0]      s2_bright;
   logic [15:0]      s2_dark;
   logic [PIX_W-1:0] s2_db [16];
   logic [PIX_W-1:0] s2_dd [16];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid  <= 1'b0;
         s2_bright <= '0;
         s2_dark   <= '0;
         for (int k = 0; k < 16; k++) begin
            s2_db[k] <= '0;
            s2_dd[k] <= '0;
         end
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_bright <= bright_c;
            s2_dark   <= dark_c;
            for (int k = 0; k < 16; k++) begin
               s2_db[k] <= db_c[k];
               s2_dd[k] <= dd_c[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------- stage 3
   logic [SCORE_W-1:0] sum_b;
   logic [SCORE_W-1:0] sum_d;
   logic [SCORE_W-1:0] score_c;
   logic [2:0]         hs_b;
   logic [2:0]         hs_d;
   logic               cand_c;

   // Sums cannot overflow: 16 * (2^PIX_W - 1) fits in PIX_W+4 bits.
   always_comb begin
      sum_b = '0;
      sum_d = '0;
      for (int k = 0; k < 16; k++) begin
         sum_b = sum_b + SCORE_W'(s2_db[k]);
         sum_d = sum_d + SCORE_W'(s2_dd[k]);
      end
      score_c = (sum_b > sum_d) ? sum_b : sum_d;
      // High-speed test looks only at the four compass pixels.
      hs_b = 3'(s2_bright[0]) + 3'(s2_bright[4]) + 3'(s2_bright[8]) + 3'(s2_bright[12]);
      hs_d = 3'(s2_dark[0])   + 3'(s2_dark[4])   + 3'(s2_dark[8])   + 3'(s2_dark[12]);
      cand_c = (int'(hs_b) >= HS_MIN) || (int'(hs_d) >= HS_MIN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_bright    <= '0;
         o_dark      <= '0;
         o_candidate <= 1'b0;
         o_score     <= '0;
      end else begin
         o_valid <= s2_valid;
         if (s2_valid) begin
            o_bright    <= s2_bright;
            o_dark      <= s2_dark;
            o_candidate <= cand_c;
            o_score     <= score_c;
         end
      end
   end

endmodule

// File: tb/tb_fast_circle_compare.sv
// -----------------------------------------------------------------------------
// Testbench for fast_circle_compare. Two instances share the stimulus: one with
// HS_MIN=2, one with HS_MIN=3 (only its candidate flag is compared). Expected
// results are queued with their due cycle when stimulus is driven and compared
// when o_valid is seen.
// -----------------------------------------------------------------------------
module tb_fast_circle_compare;

   localparam int PIX_W   = 8;
   localparam int SCORE_W = PIX_W + 4;
   localparam int CW      = 16 * PIX_W;

   logic                i_clk = 1'b0;
   logic                i_rst_n;
   logic                i_valid;
   logic [PIX_W-1:0]    i_center;
   logic [CW-1:0]       i_circle;
   logic [PIX_W-1:0]    i_threshold;
   logic                o_valid, o_candidate;
   logic [15:0]         o_bright, o_dark;
   logic [SCORE_W-1:0]  o_score;
   logic                o3_valid, o3_candidate;
   logic [15:0]         o3_bright, o3_dark;
   logic [SCORE_W-1:0]  o3_score;

   fast_circle_compare #(.PIX_W(PIX_W), .HS_MIN(2)) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
      .i_center(i_center), .i_circle(i_circle), .i_threshold(i_threshold),
      .o_valid(o_valid), .o_bright(o_bright), .o_dark(o_dark),
      .o_candidate(o_candidate), .o_score(o_score)
   );

   fast_circle_compare #(.PIX_W(PIX_W), .HS_MIN(3)) u_dut_hs3 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
      .i_center(i_center), .i_circle(i_circle), .i_threshold(i_threshold),
      .o_valid(o3_valid), .o_bright(o3_bright), .o_dark(o3_dark),
      .o_candidate(o3_candidate), .o_score(o3_score)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0]        bright;
      logic [15:0]        dark;
      logic [SCORE_W-1:0] score;
      logic               cand2;
      logic               cand3;
      int                 due;
   } exp_t;

   typedef struct {
      logic [PIX_W-1:0]   c;
      logic [PIX_W-1:0]   t;
      logic [CW-1:0]      circle;
      logic [15:0]        bright;
      logic [15:0]        dark;
      logic [SCORE_W-1:0] score;
      logic               cand2;
      logic               cand3;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model written in plain integer arithmetic.
   function automatic exp_t model(input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] t,
                                  input logic [CW-1:0] circle);
      exp_t e;
      int hi, lo, p, sbr, sdk, nb, nd;
      hi = int'(c) + int'(t);
      if (hi > (1 << PIX_W) - 1) hi = (1 << PIX_W) - 1;
      lo = int'(c) - int'(t);
      if (lo < 0) lo = 0;
      e.bright = '0; e.dark = '0;
      sbr = 0; sdk = 0; nb = 0; nd = 0;
      for (int k = 0; k < 16; k++) begin
         p = int'(circle[k*PIX_W +: PIX_W]);
         if (p > hi) begin
            e.bright[k] = 1'b1; sbr += p - hi;
            if (k % 4 == 0) nb++;
         end
         if (p < lo) begin
            e.dark[k] = 1'b1; sdk += lo - p;
            if (k % 4 == 0) nd++;
         end
      end
      e.score = SCORE_W'((sbr > sdk) ? sbr : sdk);
      e.cand2 = (nb >= 2) || (nd >= 2);
      e.cand3 = (nb >= 3) || (nd >= 3);
      e.due   = 0;
      return e;
   endfunction

   // Pixel k = sel[k] ? b : a
   function automatic logic [CW-1:0] circ(input logic [PIX_W-1:0] a, input logic [15:0] sel,
                                          input logic [PIX_W-1:0] b);
      logic [CW-1:0] r;
      for (int k = 0; k < 16; k++) r[k*PIX_W +: PIX_W] = sel[k] ? b : a;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] t,
                        input logic [CW-1:0] cir, input exp_t e);
      @(negedge i_clk);
      i_valid     = v;
      i_center    = c;
      i_threshold = t;
      i_circle    = cir;
      if (v) begin
         e.due = cyc + 3;
         sb.push_back(e);
      end
   endtask

   task automatic drive_vec(input vec_t v);
      exp_t e;
      e.bright = v.bright; e.dark = v.dark; e.score = v.score;
      e.cand2 = v.cand2; e.cand3 = v.cand3; e.due = 0;
      drive(1'b1, v.c, v.t, v.circle, e);
   endtask

   task automatic drive_rand(input logic v);
      logic [PIX_W-1:0] c, t;
      logic [CW-1:0]    cir;
      c = PIX_W'($urandom_range(0, 255));
      t = PIX_W'($urandom_range(0, 60));
      for (int k = 0; k < 16; k++) cir[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
      drive(v, c, t, cir, model(c, t, cir));
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(negedge i_clk);
         guard++;
      end
      if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Output monitor / scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1) begin
         if (o_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(o_valid), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("latency",   32'(cyc),          32'(mon_e.due));
               check("bright",    32'(o_bright),     32'(mon_e.bright));
               check("dark",      32'(o_dark),       32'(mon_e.dark));
               check("score",     32'(o_score),      32'(mon_e.score));
               check("candidate", 32'(o_candidate),  32'(mon_e.cand2));
               check("valid_hs3", 32'(o3_valid),     32'd1);
               check("cand_hs3",  32'(o3_candidate), 32'(mon_e.cand3));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("missing_valid", 32'(o_valid), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   vec_t tbl[8];

   initial begin
      logic [CW-1:0] alt;
      exp_t none;
      none = '{default: '0};

      i_rst_n = 1'b0; i_valid = 1'b0; i_center = '0; i_threshold = '0; i_circle = '0;
      #1;
      check("rst_valid",  32'(o_valid),     32'd0);
      check("rst_bright", 32'(o_bright),    32'd0);
      check("rst_dark",   32'(o_dark),      32'd0);
      check("rst_score",  32'(o_score),     32'd0);
      check("rst_cand",   32'(o_candidate), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      for (int k = 0; k < 16; k++) alt[k*PIX_W +: PIX_W] = (k % 3 == 0) ? 8'd50 : ((k % 3 == 1) ? 8'd51 : 8'd49);

      //          c       t       circle                          bright     dark       score   c2    c3
      tbl[0] = '{8'd100, 8'd20, circ(8'd130, 16'h0, 8'd0),       16'hFFFF, 16'h0000, 12'd160,  1'b1, 1'b1};
      tbl[1] = '{8'd100, 8'd20, circ(8'd100, 16'h01FF, 8'd70),   16'h0000, 16'h01FF, 12'd90,   1'b1, 1'b1};
      tbl[2] = '{8'd100, 8'd20, circ(8'd120, 16'h0, 8'd0),       16'h0000, 16'h0000, 12'd0,    1'b0, 1'b0};
      tbl[3] = '{8'd250, 8'd20, circ(8'd255, 16'h0, 8'd0),       16'h0000, 16'h0000, 12'd0,    1'b0, 1'b0};
      tbl[4] = '{8'd5,   8'd20, circ(8'd0,   16'h0, 8'd0),       16'h0000, 16'h0000, 12'd0,    1'b0, 1'b0};
      tbl[5] = '{8'd100, 8'd10, circ(8'd100, 16'h0101, 8'd200),  16'h0101, 16'h0000, 12'd180,  1'b1, 1'b0};
      tbl[6] = '{8'd50,  8'd0,  alt,                             16'h2492, 16'h4924, 12'd5,    1'b0, 1'b0};
      tbl[7] = '{8'd0,   8'd0,  circ(8'd255, 16'h0, 8'd0),       16'hFFFF, 16'h0000, 12'd4080, 1'b1, 1'b1};

      // Directed vectors, back to back.
      for (int i = 0; i < 8; i++) drive_vec(tbl[i]);
      drive(1'b0, '0, '0, '0, none);
      drain();

      // Streaming: 8 consecutive random samples (t changes each cycle), then 1,0,1,1.
      for (int i = 0; i < 8; i++) drive_rand(1'b1);
      drive_rand(1'b1);
      drive_rand(1'b0);
      drive_rand(1'b1);
      drive_rand(1'b1);
      drive(1'b0, '0, '0, '0, none);
      drain();

      // Reset with three samples in flight.
      for (int i = 0; i < 3; i++) drive_vec(tbl[0]);
      @(posedge i_clk);
      #2;
      check("pre_rst_valid",  32'(o_valid),  32'd1);
      check("pre_rst_bright", 32'(o_bright), 32'hFFFF);
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      sb.delete();
      #1;
      check("midrst_valid",     32'(o_valid),     32'd0);
      check("midrst_bright",    32'(o_bright),    32'd0);
      check("midrst_dark",      32'(o_dark),      32'd0);
      check("midrst_score",     32'(o_score),     32'd0);
      check("midrst_cand",      32'(o_candidate), 32'd0);
      check("midrst_valid_hs3", 32'(o3_valid),    32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, '0, '0, '0, none);
         check("idle_valid", 32'(o_valid), 32'd0);
      end
      drive_vec(tbl[5]);
      drive(1'b0, '0, '0, '0, none);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fast_circle_compare.md
Name: fast_circle_compare

Overview:
- Front end of the FAST keypoint path.
- Takes a centre pixel, its 16 Bresenham-circle neighbours and a threshold, and classifies each neighbour as bright, dark or similar.
- Produces the 16-bit bright and dark masks consumed by the contiguous-arc detector, plus a high-speed-test candidate flag and a corner score.
- Fully pipelined streaming block: one sample per clock, fixed latency, no backpressure.

Parameters:
- PIX_W, 8: pixel and threshold width in bits; score width is PIX_W+4.
- HS_MIN, 2: minimum same-class count among circle pixels 0,4,8,12 for o_candidate (2 is correct for 9-contiguous detection).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  sample strobe; inputs are sampled when high
- i_center  input  PIX_W  centre pixel intensity
- i_circle  input  16*PIX_W  circle pixel k at bits [k*PIX_W +: PIX_W]; k=0 at top, k increasing clockwise
- i_threshold  input  PIX_W  FAST threshold t, sampled per sample with i_valid
- o_valid  output  1  result strobe, i_valid delayed by exactly 3 cycles
- o_bright  output  16  bit k = 1 when pixel k > hi
- o_dark  output  16  bit k = 1 when pixel k < lo
- o_candidate  output  1  high-speed test pass
- o_score  output  PIX_W+4  corner score

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Clears all pipeline valid bits and all outputs to 0.
  - A reset asserted mid-stream discards every in-flight sample; o_valid drops in the same instant as reset asserts.
  - After release, the first o_valid is 3 cycles after the next i_valid.
- Pipeline: three registered stages, latency 3.
  - o_valid in cycle n+3 equals i_valid in cycle n; gaps are preserved exactly.
  - Back-to-back samples are supported every cycle.
  - Stage data registers update only when that stage's valid is high.
  - Outputs hold their last values while o_valid is low (verification checks them only when o_valid=1).
- Stage 1: compute hi = min(c+t, 2^PIX_W-1) and lo = max(c-t, 0), using a PIX_W+1-bit intermediate (saturating). Register hi, lo, circle pixels and valid. Each sample carries its own threshold.
- Stage 2, per k:
  - bright[k] = p_k > hi (strict); dark[k] = p_k < lo (strict).
  - db_k = p_k - hi if bright[k], else 0.
  - dd_k = lo - p_k if dark[k], else 0.
  - bright and dark are mutually exclusive by construction.
  - Register the masks and the 32 differences.
- Stage 3:
  - sum_b = Σdb_k and sum_d = Σdd_k, each PIX_W+4 bits. No overflow is possible: maximum 16*(2^PIX_W-1).
  - o_score = max(sum_b, sum_d).
  - o_candidate = 1 when popcount(bright[0,4,8,12]) >= HS_MIN or popcount(dark[0,4,8,12]) >= HS_MIN.
  - o_bright and o_dark are the stage-2 masks, passed through unchanged.
- Boundaries:
  - t=0 gives hi=lo=c; pixels equal to c are neither bright nor dark.
  - When hi saturates to the maximum pixel value, no pixel can be bright.
  - When lo saturates to 0, no pixel can be dark.
  - All pixels equal to c gives masks 0, score 0, candidate 0.

Test Plan:
- c=100, t=20, all p=130, single i_valid -> 3 cycles later: o_valid=1, o_bright=16'hFFFF, o_dark=0, o_score=160, o_candidate=1.
- c=100, t=20, p0..p8=70, p9..p15=100 -> o_dark=16'h01FF, o_bright=0, o_score=90, o_candidate=1.
- Equality and saturation:
  - c=100, t=20, all p=120 -> masks 0, score 0, candidate 0.
  - c=250, t=20, all p=255 -> o_bright=0.
  - c=5, t=20, all p=0 -> o_dark=0.
- Streaming: i_valid high 8 consecutive cycles, then pattern 1,0,1,1 -> o_valid reproduces the same pattern shifted by 3. Each result matches its own (c, t, circle) even when t changes every cycle.
- Mixed high-speed test: c=100, t=10, only p0 and p8 = 200, rest 100 -> o_bright=16'h0101, o_candidate=1 with HS_MIN=2. Same stimulus with HS_MIN=3 -> o_candidate=0.
- Reset mid-stream: assert i_rst_n=0 while 3 samples are in flight -> o_valid and all outputs go to 0 immediately. After release with no i_valid -> o_valid stays 0. Next i_valid -> o_valid exactly 3 cycles later.
